// File: rtl/run_interruption_update.sv
// JPEG-LS run-interruption stage: selects the RItype context, searches Golomb k serially,
// maps Errval to EMErrval and produces the updated (A, Nn, N) context for write-back.
module run_interruption_update #(
    parameter int unsigned RESET_TH = 64,
    parameter int unsigned K_MAX    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        ri_type,
    input  logic [7:0]  errval,
    input  logic [12:0] A_0,
    input  logic [12:0] A_1,
    input  logic [6:0]  Nn_0,
    input  logic [6:0]  Nn_1,
    input  logic [6:0]  N_0,
    input  logic [6:0]  N_1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  k,
    output logic [8:0]  emerrval,
    output logic        ctx_we,
    output logic        ctx_ritype,
    output logic [12:0] A_new,
    output logic [6:0]  Nn_new,
    output logic [6:0]  N_new
);

    typedef enum logic [1:0] {IDLE, KCALC, EMIT} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_err;
    logic        r_ri;
    logic [12:0] r_a;
    logic [6:0]  r_nn, r_n;
    logic [13:0] r_temp;
    logic [3:0]  r_k, r_k_out;
    logic [8:0]  r_em;
    logic [12:0] r_a_new;
    logic [6:0]  r_nn_new, r_n_new;
    logic        r_ctx_ri, r_we;

    logic [12:0] w_sel_a;
    logic [6:0]  w_sel_nn, w_sel_n;
    logic [13:0] w_temp;
    logic [20:0] w_shift;
    logic        w_kdone;
    logic        w_neg, w_pos, w_map, w_half;
    logic [7:0]  w_abs, w_nn2, w_n8, w_nnp;
    logic [8:0]  w_em;
    logic [9:0]  w_inc;
    logic [13:0] w_asum;
    logic [12:0] w_asat, w_a_fin;
    logic [6:0]  w_nn_fin, w_n_fin;

    assign w_sel_a  = ri_type ? A_1  : A_0;
    assign w_sel_nn = ri_type ? Nn_1 : Nn_0;
    assign w_sel_n  = ri_type ? N_1  : N_0;
    assign w_temp   = ri_type ? ({1'b0, w_sel_a} + {8'd0, w_sel_n[6:1]}) : {1'b0, w_sel_a};

    assign w_shift = 21'(r_n) << r_k;
    assign w_kdone = (w_shift >= {7'd0, r_temp}) || (r_k == 4'(K_MAX));

    // Error mapping; errval==0 forces map=0 and the result clamps to zero.
    assign w_neg = r_err[7];
    assign w_pos = !r_err[7] && (r_err != 8'd0);
    assign w_abs = w_neg ? (8'd0 - r_err) : r_err;
    assign w_nn2 = {r_nn, 1'b0};
    assign w_n8  = {1'b0, r_n};
    assign w_map = (r_k == 4'd0 && w_pos && w_nn2 < w_n8)
                || (w_neg && w_nn2 >= w_n8)
                || (w_neg && r_k != 4'd0);
    assign w_em  = (r_err == 8'd0) ? '0
                 : ({w_abs, 1'b0} - {8'd0, r_ri} - {8'd0, w_map});

    assign w_inc    = ({1'b0, w_em} + 10'd1 - {9'd0, r_ri}) >> 1;
    assign w_asum   = {1'b0, r_a} + {4'd0, w_inc};
    assign w_asat   = w_asum[13] ? '1 : w_asum[12:0];
    assign w_nnp    = {1'b0, r_nn} + {7'd0, w_neg};
    assign w_half   = (r_n == 7'(RESET_TH));
    assign w_a_fin  = w_half ? (w_asat >> 1) : w_asat;
    assign w_nn_fin = w_half ? w_nnp[7:1] : w_nnp[6:0];
    assign w_n_fin  = (w_half ? (r_n >> 1) : r_n) + 7'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = KCALC;
            end
            KCALC: if (w_kdone) w_next = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err    <= '0;
            r_ri     <= 1'b0;
            r_a      <= '0;
            r_nn     <= '0;
            r_n      <= '0;
            r_temp   <= '0;
            r_k      <= '0;
            r_k_out  <= '0;
            r_em     <= '0;
            r_a_new  <= '0;
            r_nn_new <= '0;
            r_n_new  <= '0;
            r_ctx_ri <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_err  <= errval;
                    r_ri   <= ri_type;
                    r_a    <= w_sel_a;
                    r_nn   <= w_sel_nn;
                    r_n    <= w_sel_n;
                    r_temp <= w_temp;
                    r_k    <= '0;
                end
                KCALC: if (w_kdone) begin
                    r_k_out  <= r_k;
                    r_em     <= w_em;
                    r_a_new  <= w_a_fin;
                    r_nn_new <= w_nn_fin;
                    r_n_new  <= w_n_fin;
                    r_ctx_ri <= r_ri;
                    r_we     <= 1'b1;
                end else begin
                    r_k <= r_k + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign k          = r_k_out;
    assign emerrval   = r_em;
    assign ctx_we     = r_we;
    assign ctx_ritype = r_ctx_ri;
    assign A_new      = r_a_new;
    assign Nn_new     = r_nn_new;
    assign N_new      = r_n_new;

endmodule
